led_gpio_ctrl: RTL and testbench
================================

Name: led_gpio_ctrl

Overview:
- Sits between the PS7 EMIO GPIO outputs and the board LED pins (LED_RED = led[0], LED_GREEN = led[1]).
- Accepts per-LED configuration commands that software writes over GPIO: mode (off, on, slow blink, fast blink, heartbeat) plus 4-bit brightness.
- Drives the LEDs with timed patterns and PWM dimming.
- Echoes the last accepted command on a status bus, returned to the PS on the GPIO inputs.

Parameters:
- CLK_HZ, 25000000, frequency of clk in Hz.
- TICK_HZ, 1000, timebase tick rate; one tick = one pattern "ms".
- NLED, 2, number of LED outputs (1..8).

Ports:
- clk  in  1  fabric clock (fclk[1]).
- rst_n  in  1  reset.
- gpio_in  in  16  raw EMIO GPIO output slice; asynchronous to clk.
- led  out  NLED  LED drive, 1 = lit.
- gpio_out  out  16  status to EMIO GPIO input.

Reset is asynchronous, active-low (rst_n); all logic runs on the single clock clk.

Behaviour:
- Command format on gpio_in:
  - [15] write toggle.
  - [14:12] LED index.
  - [11:8] brightness.
  - [7:3] reserved, ignored.
  - [2:0] mode.
- Software must set the data fields and the toggle in separate GPIO writes.
- Synchronizer: all 16 bits pass through a 2-flop chain.
  - A write is detected when synced bit 15 differs from the registered previous value.
  - Data fields are captured from the synced copy in that same cycle.
- Settle after reset: edge detection is disabled for 3 clk after rst_n deasserts. During this window the previous-toggle register tracks synced bit 15, so a toggle already at 1 does not cause a spurious write.
- Per-LED config registers (mode, bright) reset to mode=0, bright=15.
- Valid write (index < NLED): update that LED's config in the detect cycle.
- Invalid index: no config changes; the error flag is set.
- gpio_out, registered; updated 1 clk after detect for every write, valid or invalid:
  - [15] ack = accepted toggle value.
  - [14:12] index.
  - [11:8] bright.
  - [7] error, sticky until the next valid write.
  - [2:0] mode.
  - Other bits are 0. Reset value is all zeros.
- Latency: gpio_in toggle edge to config update is at most 3 clk; led reflects the new config 1 clk later (led is registered).
- Timebase:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1; the wrap emits a 1-clk tick.
  - Shared phase counter counts 0..999 on each tick, then wraps to 0.
  - Writes never reset the prescaler or phase, so all LEDs stay phase-aligned.
- Pattern by mode (p = phase):
  - 0: off.
  - 1: on.
  - 2 slow blink: on when p < 500.
  - 3 fast blink: on when (p mod 250) < 125.
  - 4 heartbeat: on when p < 100 or 200 <= p < 300.
  - 5, 6, 7: off (but see Optional Feature for mode 5).
- PWM:
  - 4-bit free-running counter pwm increments every clk and wraps 15 -> 0.
  - lit = pattern AND (bright == 15 OR pwm < bright).
  - bright 0 always gives dark.
- Reset value: led = 0, prescaler = 0, phase = 0, pwm = 0.
- Reset asserted mid-pattern: everything clears at once, and the settle window applies again.

Optional Feature:
- Macro LED_BREATHE_EN.
- Defined: mode 5 = breathe.
  - tri = (p < 500 ? p : 999 - p) >> 5, giving a 0..15 triangle.
  - eff = min(bright, tri).
  - lit = (eff == 15) OR (pwm < eff).
- Undefined: mode 5 is reserved and gives off. The extra comparator/shift logic is absent.

Decomposition:
- Package led_gpio_pkg holds:
  - typedef led_mode_e (OFF=0, ON=1, SLOW=2, FAST=3, HEART=4, BREATHE=5).
  - Field position constants for the gpio_in/gpio_out bits.
  - Phase constants: PERIOD=1000, SLOW_ON=500, FAST_PER=250, FAST_ON=125, HB pulse edges 100/200/300.
- Sub-module led_timebase: prescaler, tick, phase and pwm counters; instantiated once.
- Per-LED pattern/PWM logic lives in a generate loop in led_gpio_ctrl.

Test Plan:
- Bench parameters: CLK_HZ=16000, TICK_HZ=1000, so 16 clk per ms.
- Reset release with gpio_in=16'h8000 -> no write; gpio_out=0 and led=0 after settle; ack stays 0.
- gpio_in=16'h0F02, then 16'h8F02 -> within 3 clk config[0]=SLOW, bright=15; gpio_out=16'h8F02 one clk later; led[0]=1 for phases 0..499 and 0 for 500..999.
- gpio_in=16'h1401, toggle bit 15 to 0 (16'h1401) -> led[1] lit exactly 4 of every 16 clk.
- Index 5 with NLED=2 (gpio_in=16'hDF01 after prior toggle 0) -> no config change; gpio_out[7]=1; ack=1. A following valid write clears gpio_out[7].
- Mode 4 on led[0], bright=15 -> led high for ms 0..99 and 200..299, low elsewhere, repeating every 1000 ms.
- With LED_BREATHE_EN, mode 5, bright=15 -> eff=0 at p=0, eff=15 at p=480..519. Without the macro -> led stays 0.

Source files
------------

// File: rtl/led_gpio_pkg.sv
// Shared types and constants for the EMIO GPIO driven LED controller.
// Mode 5 (breathe) is only decoded when LED_BREATHE_EN is defined.
package led_gpio_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        ON      = 3'd1,
        SLOW    = 3'd2,
        FAST    = 3'd3,
        HEART   = 3'd4,
        BREATHE = 3'd5
    } led_mode_e;

    // Command / status field positions
    localparam int unsigned TOG_BIT    = 15;
    localparam int unsigned IDX_LSB    = 12;
    localparam int unsigned BRIGHT_LSB = 8;
    localparam int unsigned ERR_BIT    = 7;
    localparam int unsigned MODE_LSB   = 0;

    // Status echoes toggle, index, brightness and mode in place
    localparam logic [15:0] ECHO_MASK = 16'hFF07;

    localparam int unsigned SETTLE_CLK = 3;

    localparam logic [9:0] PERIOD   = 10'd1000;
    localparam logic [9:0] SLOW_ON  = 10'd500;
    localparam logic [9:0] FAST_PER = 10'd250;
    localparam logic [9:0] FAST_ON  = 10'd125;
    localparam logic [9:0] HB_ON1   = 10'd100;
    localparam logic [9:0] HB_ON2   = 10'd200;
    localparam logic [9:0] HB_OFF2  = 10'd300;

    function automatic logic pattern_on(input logic [2:0] mode, input logic [9:0] p);
        logic on;
        on = 1'b0;
        case (led_mode_e'(mode))
            ON:      on = 1'b1;
            SLOW:    on = (p < SLOW_ON);
            FAST:    on = ((p % FAST_PER) < FAST_ON);
            HEART:   on = (p < HB_ON1) || ((p >= HB_ON2) && (p < HB_OFF2));
`ifdef LED_BREATHE_EN
            BREATHE: on = 1'b1;
`endif
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/led_gpio_ctrl_timebase.sv
// Shared LED timebase: ms prescaler, 0..999 phase counter and 4-bit PWM ramp.
module led_timebase #(
    parameter int unsigned CLK_HZ  = 25000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] phase_o,
    output logic [3:0] pwm_o
);
    import led_gpio_pkg::*;

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [9:0]    phase_q;
    logic [3:0]    pwm_q;
    logic          tick;

    assign tick = (presc_q == PW'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            phase_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            pwm_q   <= pwm_q + 4'd1;
            if (tick) begin
                phase_q <= (phase_q == PERIOD - 10'd1) ? '0 : phase_q + 10'd1;
            end
        end
    end

    assign phase_o = phase_q;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/led_gpio_ctrl.sv
// LED controller fed by PS7 EMIO GPIO commands; echoes each write on gpio_out.
// Define LED_BREATHE_EN to enable mode 5 (breathe); otherwise mode 5 is dark.
module led_gpio_ctrl #(
    parameter int unsigned CLK_HZ  = 25000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned NLED    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     gpio_in,
    output logic [NLED-1:0] led,
    output logic [15:0]     gpio_out
);
    import led_gpio_pkg::*;

    logic [15:0]     sync1_q, sync2_q;
    logic            tog_prev_q;
    logic [1:0]      settle_q;
    logic            wr, idx_ok;
    logic [2:0]      wr_idx;
    logic [2:0]      mode_q   [NLED];
    logic [3:0]      bright_q [NLED];
    logic            err_q, err_d;
    logic [15:0]     status_q, status_d;
    logic [NLED-1:0] led_q, led_d;
    logic [9:0]      phase;
    logic [3:0]      pwm;

    led_timebase #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_timebase (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .phase_o(phase),
        .pwm_o  (pwm)
    );

    assign wr_idx = sync2_q[IDX_LSB +: 3];
    assign idx_ok = ({1'b0, wr_idx} < 4'(NLED));
    assign wr     = (settle_q == 2'(SETTLE_CLK)) && (sync2_q[TOG_BIT] != tog_prev_q);

    // Previous toggle follows the synced bit even while settling, so a toggle
    // already high at reset release is absorbed rather than seen as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tog_prev_q <= 1'b0;
            settle_q   <= '0;
        end else begin
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            tog_prev_q <= sync2_q[TOG_BIT];
            if (settle_q != 2'(SETTLE_CLK)) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NLED; i++) begin
                mode_q[i]   <= '0;
                bright_q[i] <= '1;
            end
        end else begin
            for (int unsigned i = 0; i < NLED; i++) begin
                if (wr && idx_ok && (wr_idx == 3'(i))) begin
                    mode_q[i]   <= sync2_q[MODE_LSB +: 3];
                    bright_q[i] <= sync2_q[BRIGHT_LSB +: 4];
                end
            end
        end
    end

    always_comb begin
        err_d    = err_q;
        status_d = status_q;
        if (wr) begin
            err_d             = !idx_ok;
            status_d          = sync2_q & ECHO_MASK;
            status_d[ERR_BIT] = err_d;
        end
    end

`ifdef LED_BREATHE_EN
    logic [9:0] fold;
    logic [3:0] tri_lvl;
    assign fold    = (phase < SLOW_ON) ? phase : (PERIOD - 10'd1 - phase);
    assign tri_lvl = 4'(fold >> 5);
`endif

    for (genvar g = 0; g < NLED; g++) begin : g_led
        logic [3:0] eff;
`ifdef LED_BREATHE_EN
        assign eff = ((mode_q[g] == BREATHE) && (tri_lvl < bright_q[g])) ? tri_lvl : bright_q[g];
`else
        assign eff = bright_q[g];
`endif
        assign led_d[g] = pattern_on(mode_q[g], phase) && ((eff == 4'hF) || (pwm < eff));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            status_q <= '0;
            led_q    <= '0;
        end else begin
            err_q    <= err_d;
            status_q <= status_d;
            led_q    <= led_d;
        end
    end

    assign led      = led_q;
    assign gpio_out = status_q;

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// Directed bench for led_gpio_ctrl at 16 clk per ms (CLK_HZ=16000, TICK_HZ=1000).
module tb_led_gpio_ctrl;

    localparam int unsigned NLED = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [15:0]     gpio_in;
    logic [15:0]     gpio_out;
    logic [NLED-1:0] led;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ncyc;
    logic cur_tog;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp_out;
        bit          chk_lat;
    } vec_t;

    vec_t vecs[9];

    led_gpio_ctrl #(
        .CLK_HZ (16000),
        .TICK_HZ(1000),
        .NLED   (NLED)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gpio_in (gpio_in),
        .led     (led),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the timebase state after n edges is
    // pwm = n % 16, phase = (n / 16) % 1000.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Expected led after n edges: registered from the state after n-1 edges.
    function automatic logic model_lit(input int mode, input int br, input int n);
        int   pp, p, w, lvl;
        logic pat;
        pp  = n - 1;
        p   = (pp / 16) % 1000;
        w   = pp % 16;
        lvl = br;
        pat = 1'b0;
        case (mode)
            1: pat = 1'b1;
            2: pat = (p < 500);
            3: pat = ((p % 250) < 125);
            4: pat = (p < 100) || (p >= 200 && p < 300);
`ifdef LED_BREATHE_EN
            5: begin
                int fold;
                pat  = 1'b1;
                fold = (p < 500) ? p : 999 - p;
                if ((fold >> 5) < br) lvl = fold >> 5;
            end
`endif
            default: pat = 1'b0;
        endcase
        return pat && ((lvl == 15) || (w < lvl));
    endfunction

    task automatic check_window(input string name, input int idx, input int mode, input int br,
                                input int cycles, input int exp_lit_cnt);
        int bad;
        int lit;
        bad = 0;
        lit = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (led[idx]) lit++;
            if (led[idx] !== model_lit(mode, br, ncyc)) bad++;
        end
        chk({name, "_bad_cycles"}, bad, 0);
        chk({name, "_lit_cycles"}, lit, exp_lit_cnt);
    endtask

    // Data fields first with the old toggle, then flip the toggle alone.
    task automatic send(input logic [15:0] cmd, input logic [15:0] exp, output int lat);
        gpio_in = {cur_tog, cmd[14:0]};
        repeat (3) @(negedge clk);
        gpio_in = cmd;
        cur_tog = cmd[15];
        lat     = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (lat < 0 && gpio_out == exp) lat = k;
        end
    endtask

    initial begin
        int bad;
        int lat;

        vecs[0] = '{16'h0F02, 16'h0F02, 1'b1};
        vecs[1] = '{16'h8F02, 16'h8F02, 1'b1};
        vecs[2] = '{16'h1401, 16'h1401, 1'b1};
        vecs[3] = '{16'hDF01, 16'hDF81, 1'b1};
        vecs[4] = '{16'h0F02, 16'h0F02, 1'b1};
        vecs[5] = '{16'hF8FB, 16'hF883, 1'b1};
        vecs[6] = '{16'h9A05, 16'hF883, 1'b0};
        vecs[7] = '{16'h0F02, 16'h0F02, 1'b1};
        vecs[8] = '{16'h8FFA, 16'h8F02, 1'b1};

        rst_n   = 1'b0;
        gpio_in = 16'h8000;
        cur_tog = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_gpio_out", gpio_out, 0);
        chk("reset_led", led, 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gpio_out != 16'h0000 || led != '0) bad++;
        end
        chk("settle_no_spurious_write", bad, 0);

        foreach (vecs[i]) begin
            send(vecs[i].cmd, vecs[i].exp_out, lat);
            chk($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_out);
            if (vecs[i].chk_lat) begin
                n_cmp++;
                if (lat < 1 || lat > 4) begin
                    n_fail++;
                    $display("FAIL vec%0d_latency: got %0d clk, want 1..4", i, lat);
                end
            end
        end

        // led0 = slow blink bright 15, led1 = on bright 4
        check_window("led1_pwm4", 1, 1, 4, 48, 12);
        check_window("led0_slow", 0, 2, 15, 16000, 8000);

        send(16'h0F04, 16'h0F04, lat);
        check_window("led0_heart", 0, 4, 15, 16000, 3200);

        send(16'h8F05, 16'h8F05, lat);
`ifdef LED_BREATHE_EN
        check_window("led0_mode5", 0, 5, 15, 16000, 7360);
`else
        check_window("led0_mode5", 0, 5, 15, 16000, 0);
`endif

        send(16'h1001, 16'h1001, lat);
        check_window("led1_bright0", 1, 1, 0, 32, 0);
        send(16'h9F01, 16'h9F01, lat);
        check_window("led1_bright15", 1, 1, 15, 32, 32);

        // Asynchronous reset mid-pattern with the toggle left high
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_led", led, 0);
        chk("midreset_gpio_out", gpio_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gpio_out != 16'h0000 || led != '0) bad++;
        end
        chk("midreset_resettle", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
